vga_sync_generator: RTL
=======================

Name: vga_sync_generator

Overview:
- Produces the 640x480@60 Hz raster timing consumed by GameOfLife: pixel position (row, column), displayActive, and the hsync/vsync pins.
- Also produces two pulses for the pixel pipeline:
  - drawRequest, once per frame at the start of vertical blanking, when the board update may run.
  - lineFetch, once per line, so the next line can be prefetched from SDRAM.
- Sits between the clock divider/top level and GameOfLife.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=1)
SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous, active-high reset
row  output  9  current visible line, 0..479
column  output  10  horizontal count, 0..H_TOTAL-1
displayActive  output  1  high while position is inside the visible 640x480 area
hsync  output  1  horizontal sync pin
vsync  output  1  vertical sync pin
drawRequest  output  1  one-clk pulse at entry to vertical blanking
lineFetch  output  1  one-clk pulse requesting prefetch of the next visible line
frameCount  output  8  frames completed, wraps 255->0

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters (800).
  - V_TOTAL = sum of the V_* parameters (525).
- Pixel divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixEn = (div == CLK_DIV-1).
  - CLK_DIV=1 gives pixEn every clk.
- Counters:
  - hCount is 10 bits; vCount is 10 bits internally.
  - On pixEn, hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - vCount wraps to 0 after V_TOTAL-1.
  - Counters hold when pixEn=0.
- Outputs are registered from the current counter values: one clk latency after each counter change. All outputs are glitch-free.
  - column = hCount.
  - row = vCount[8:0] while vCount < V_VISIBLE; otherwise row holds V_VISIBLE-1 (479). It never wraps through 480..524.
  - displayActive = (hCount < H_VISIBLE) && (vCount < V_VISIBLE).
  - hsync = SYNC_ACTIVE when hCount is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751); otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE when vCount is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491); otherwise ~SYNC_ACTIVE.
- drawRequest:
  - High for exactly one clk, on the clk after the counters move from (h=H_TOTAL-1, v=V_VISIBLE-1) to (0, V_VISIBLE).
  - Exactly one pulse per frame.
- lineFetch:
  - High for exactly one clk, on the clk after hCount becomes H_VISIBLE (640).
  - Fires only when the following line is visible: vCount < V_VISIBLE-1, or vCount == V_TOTAL-1 (prefetch of line 0).
  - Exactly 480 pulses per frame.
- frameCount increments (mod 256) on the same clk that the vCount wrap V_TOTAL-1 -> 0 takes effect.
- Reset (any time, including mid-line or mid-sync):
  - div, hCount, vCount and frameCount become 0.
  - row=0, column=0, displayActive=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - drawRequest=0, lineFetch=0.
  - Any pulse in flight is cancelled.
  - On the first clk after rst deasserts, outputs reflect position (0,0): displayActive=1.
- Frame period is H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).
- Simultaneous events:
  - Line wrap and frame wrap on the same pixEn: both counters update together, and frameCount increments once.
  - drawRequest and lineFetch never coincide at defaults.

Test Plan:
- Reset check: hold rst 3 clks -> column=0, row=0, displayActive=0, hsync=vsync=1, drawRequest=0, frameCount=0. After release: displayActive=1, with column advancing every 2 clks.
- Horizontal timing, CLK_DIV=2: displayActive falls when column goes 639->640. hsync is low for exactly 192 clks, starting at column=656 and ending at column=752. Line period is 1600 clks.
- Vertical timing over one full frame:
  - vsync is low for exactly 2 lines (3200 clks) starting at vCount=490.
  - row holds 479 through all blanking lines.
  - Frame period is 840000 clks; frameCount goes 0->1.
- Pulse counts over one frame: drawRequest count = 1, 1 clk wide, at the (639... end of line 479)->line 480 transition. lineFetch count = 480, each 1 clk wide, with no pulse on the lines starting at vCount 479..523.
- Reset mid-operation: assert rst at column=700 (during hsync), row=200 -> hsync=1 on the next clk and counters at 0. The following frame again measures 840000 clks.
- CLK_DIV=1 parameter run: column advances every clk, the frame is 420000 clks, and the 255->0 frameCount wrap is checked after 256 frames with a forced counter preload via a bench hierarchical deposit.

Source files
------------

// File: rtl/vga_sync_generator.sv
`timescale 1ns/1ps
// vga_sync_generator: 640x480@60 raster timing. A pixel-enable divider steps
// the horizontal/vertical counters; every output is registered from the
// current counter values, so outputs lag the counters by one clk and are
// glitch-free. drawRequest and lineFetch are one-clk pulses aligned with the
// first clk on which the registered position shows their trigger pixel.
module vga_sync_generator #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   CLK_DIV     = 2,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       displayActive,
  output logic       hsync,
  output logic       vsync,
  output logic       drawRequest,
  output logic       lineFetch,
  output logic [7:0] frameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_PRE    = 10'(V_VISIBLE - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [8:0] ROW_MAX  = 9'(V_VISIBLE - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [7:0]       frame_q, frame_d;
  logic             pix_en;

  logic [8:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       draw_q, draw_d;
  logic       fetch_q, fetch_d;
  logic       moved;

  // Divider and raster counters: advance one pixel per pixEn, wrap line then frame
  always_comb begin
    pix_en  = (div_q == DIV_LAST);
    div_d   = pix_en ? '0 : div_q + DIV_W'(1);
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Output decode from the current counters; registered below
  always_comb begin
    // div_q==0 marks the first clk at a new position (just after reset the
    // position is (0,0), which is never a pulse trigger)
    moved    = (div_q == '0);
    col_d    = h_q;
    row_d    = (v_q < V_VIS) ? v_q[8:0] : ROW_MAX;
    active_d = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d  = ((h_q >= HS_START) && (h_q <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d  = ((v_q >= VS_START) && (v_q <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    draw_d   = moved && (h_q == '0) && (v_q == V_VIS);
    fetch_d  = moved && (h_q == H_VIS) && ((v_q < V_PRE) || (v_q == V_LAST));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      frame_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
      draw_q   <= 1'b0;
      fetch_q  <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      frame_q  <= frame_d;
      row_q    <= row_d;
      col_q    <= col_d;
      active_q <= active_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      draw_q   <= draw_d;
      fetch_q  <= fetch_d;
    end
  end

  assign row           = row_q;
  assign column        = col_q;
  assign displayActive = active_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign drawRequest   = draw_q;
  assign lineFetch     = fetch_q;
  assign frameCount    = frame_q;

endmodule
